// File: rtl/tl_d_channel_arbiter.sv
// ---------------------------------------------------------------------------
// tl_d_channel_arbiter
//
// Round-robin arbiter that merges TileLink D-channel responses from N_REQ
// requesters into one shared downstream D queue. Once the first beat of a
// multi-beat data message (AccessAckData / GrantData) is accepted, the grant
// is locked to that requester until the last beat fires, so beats of
// different messages never interleave. The payload mux and valid/ready path
// are purely combinational; only the round-robin pointer, lock owner, burst
// state and remaining-beat counter are registered.
//
// Optional feature (macro DARB_STALL_CNT_EN):
//   adds output stall_cnt[15:0], counting cycles in which any requester is
//   valid but nothing is transferred downstream. Saturates at 16'hFFFF and
//   is cleared by reset. Without the macro the port and counter are absent.
//
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   in_valid/in_ready   per-requester handshake (bit i = requester i)
//   in_opcode..corrupt  per-requester D fields, requester i at [i*W +: W]
//   out_valid/out_ready handshake toward the downstream queue
//   out_opcode..corrupt muxed payload of the selected requester
//   stall_cnt           stall counter (only with DARB_STALL_CNT_EN)
//   grant_idx           currently selected requester (debug)
// ---------------------------------------------------------------------------
module tl_d_channel_arbiter #(
  parameter int N_REQ      = 2,
  parameter int BEAT_BYTES = 8,
  parameter int CNT_W      = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           in_valid,
  output logic [N_REQ-1:0]           in_ready,
  input  logic [3*N_REQ-1:0]         in_opcode,
  input  logic [2*N_REQ-1:0]         in_param,
  input  logic [4*N_REQ-1:0]         in_size,
  input  logic [5*N_REQ-1:0]         in_source,
  input  logic [3*N_REQ-1:0]         in_sink,
  input  logic [N_REQ-1:0]           in_denied,
  input  logic [BEAT_BYTES*8*N_REQ-1:0] in_data,
  input  logic [N_REQ-1:0]           in_corrupt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_opcode,
  output logic [1:0]                 out_param,
  output logic [3:0]                 out_size,
  output logic [4:0]                 out_source,
  output logic [2:0]                 out_sink,
  output logic                       out_denied,
  output logic [BEAT_BYTES*8-1:0]    out_data,
  output logic                       out_corrupt,
`ifdef DARB_STALL_CNT_EN
  output logic [15:0]                stall_cnt,
`endif
  output logic [2:0]                 grant_idx
);

  localparam int DW = BEAT_BYTES * 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [2:0]       lock_q, lock_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Zero-extended valid vector so a 3-bit index is always in range.
  logic [7:0] valid_pad;
  assign valid_pad = 8'(in_valid);

  // ---------------------------------------------------------------------
  // Round-robin winner: first valid requester starting at rr_ptr, wrapping
  // modulo N_REQ (works for non-power-of-two N_REQ).
  // ---------------------------------------------------------------------
  logic       win_found;
  logic [2:0] win_idx;
  logic [3:0] scan_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    scan_idx  = 4'd0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + 4'(k);
      if (scan_idx >= 4'(N_REQ)) begin
        scan_idx = scan_idx - 4'(N_REQ);
      end
      if (!win_found && valid_pad[scan_idx[2:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[2:0];
      end
    end
  end

  // While a burst is in progress only the lock owner is considered.
  logic [2:0] sel;
  logic       grant_ok;
  assign sel       = (state_q == BURST) ? lock_q : win_idx;
  assign grant_ok  = !reset && ((state_q == BURST) || win_found);
  assign grant_idx = reset ? 3'd0 : sel;

  always_comb begin
    out_valid = 1'b0;
    if (!reset) begin
      out_valid = (state_q == BURST) ? valid_pad[lock_q] : (|in_valid);
    end
  end

  // ---------------------------------------------------------------------
  // Payload mux
  // ---------------------------------------------------------------------
  always_comb begin
    out_opcode  = 3'd0;
    out_param   = 2'd0;
    out_size    = 4'd0;
    out_source  = 5'd0;
    out_sink    = 3'd0;
    out_denied  = 1'b0;
    out_data    = '0;
    out_corrupt = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel == 3'(i)) begin
        out_opcode  = in_opcode[i*3 +: 3];
        out_param   = in_param[i*2 +: 2];
        out_size    = in_size[i*4 +: 4];
        out_source  = in_source[i*5 +: 5];
        out_sink    = in_sink[i*3 +: 3];
        out_denied  = in_denied[i];
        out_data    = in_data[i*DW +: DW];
        out_corrupt = in_corrupt[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign in_ready[gi] = grant_ok && out_ready && (sel == 3'(gi));
    end
  endgenerate

  logic fire;
  assign fire = out_valid && out_ready;

  // ---------------------------------------------------------------------
  // Beats remaining after the first one, derived from the first beat.
  // Data-bearing messages larger than one beat span 2^(size-3) beats; the
  // count saturates at 2^CNT_W, i.e. beats-1 saturates at all ones.
  // ---------------------------------------------------------------------
  logic             is_data;
  logic [3:0]       shamt;
  logic [CNT_W-1:0] beats_m1;

  always_comb begin
    is_data  = (out_opcode == 3'd1) || (out_opcode == 3'd5);
    shamt    = 4'd0;
    beats_m1 = '0;
    if (is_data && (out_size > 4'd3)) begin
      shamt = out_size - 4'd3;
      if (int'(shamt) >= CNT_W) begin
        beats_m1 = '1;
      end else begin
        beats_m1 = CNT_W'((32'd1 << shamt) - 32'd1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          rr_ptr_d = (win_idx == 3'(N_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
          if (beats_m1 != '0) begin
            state_d    = BURST;
            lock_d     = win_idx;
            beat_cnt_d = beats_m1;
          end
        end
      end
      BURST: begin
        if (fire) begin
          if (beat_cnt_q == CNT_W'(1)) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 3'd0;
      lock_q     <= 3'd0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef DARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|in_valid) && !fire && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tl_d_channel_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for tl_d_channel_arbiter (N_REQ=2). Directed scenarios use
// constant expectations; the randomized scenario is checked against a
// behavioural model holding the round-robin pointer, lock owner and beats
// left as plain integers.
// ---------------------------------------------------------------------------
module tb_tl_d_channel_arbiter;

  localparam int N = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [3*N-1:0] in_opcode = '0;
  logic [2*N-1:0] in_param = '0;
  logic [4*N-1:0] in_size = '0;
  logic [5*N-1:0] in_source = '0;
  logic [3*N-1:0] in_sink = '0;
  logic [N-1:0]   in_denied = '0;
  logic [64*N-1:0] in_data = '0;
  logic [N-1:0]   in_corrupt = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2:0]     out_opcode;
  logic [1:0]     out_param;
  logic [3:0]     out_size;
  logic [4:0]     out_source;
  logic [2:0]     out_sink;
  logic           out_denied;
  logic [63:0]    out_data;
  logic           out_corrupt;
  logic [2:0]     grant_idx;
`ifdef DARB_STALL_CNT_EN
  logic [15:0]    stall_cnt;
`endif

  always #5 clock = ~clock;

  tl_d_channel_arbiter #(.N_REQ(N), .BEAT_BYTES(8), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_param(in_param), .in_size(in_size),
    .in_source(in_source), .in_sink(in_sink), .in_denied(in_denied),
    .in_data(in_data), .in_corrupt(in_corrupt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_param(out_param), .out_size(out_size),
    .out_source(out_source), .out_sink(out_sink), .out_denied(out_denied),
    .out_data(out_data), .out_corrupt(out_corrupt),
`ifdef DARB_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .grant_idx(grant_idx)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int         m_ptr  = 0;
  int         m_lock = -1;
  int         m_left = 0;
  int         e_sel;
  bit         e_valid;
  logic [N-1:0] e_ready;

  task automatic drive_req(input int i, input bit v, input int op, input int sz);
    in_valid[i]          = v;
    in_opcode[i*3 +: 3]  = 3'(op);
    in_size[i*4 +: 4]    = 4'(sz);
    in_param[i*2 +: 2]   = 2'($urandom);
    in_source[i*5 +: 5]  = 5'($urandom);
    in_sink[i*3 +: 3]    = 3'($urandom);
    in_denied[i]         = 1'($urandom);
    in_corrupt[i]        = 1'($urandom);
    in_data[i*64 +: 64]  = {$urandom, $urandom};
  endtask

  function automatic logic [82:0] payload_of(input int i);
    return {in_opcode[i*3 +: 3], in_param[i*2 +: 2], in_size[i*4 +: 4],
            in_source[i*5 +: 5], in_sink[i*3 +: 3], in_denied[i],
            in_data[i*64 +: 64], in_corrupt[i]};
  endfunction

  function automatic logic [82:0] out_payload();
    return {out_opcode, out_param, out_size, out_source, out_sink,
            out_denied, out_data, out_corrupt};
  endfunction

  // Message length in beats: 8-byte beats, data opcodes only, capped at 256.
  function automatic int beats_of(input int op, input int sz);
    int b;
    b = 1;
    if ((op == 1 || op == 5) && sz > 3) begin
      b = 1 << (sz - 3);
      if (b > 256) b = 256;
    end
    return b;
  endfunction

  function automatic void model_reset();
    m_ptr  = 0;
    m_lock = -1;
    m_left = 0;
  endfunction

  function automatic void model_eval();
    bit granted;
    e_sel   = 0;
    e_valid = 1'b0;
    e_ready = '0;
    granted = 1'b0;
    if (!reset) begin
      if (m_lock >= 0) begin
        e_sel   = m_lock;
        e_valid = in_valid[m_lock];
        granted = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (in_valid[j]) begin
            e_sel   = j;
            e_valid = 1'b1;
            granted = 1'b1;
            break;
          end
        end
      end
      if (granted && out_ready) e_ready = N'(1 << e_sel);
    end
  endfunction

  function automatic void model_step();
    int b;
    if (reset) begin
      model_reset();
    end else if (e_valid && out_ready) begin
      $display("beat req=%0d op=%0d size=%0d lock=%0d left=%0d",
               e_sel, in_opcode[e_sel*3 +: 3], in_size[e_sel*4 +: 4], m_lock, m_left);
      if (m_lock < 0) begin
        m_ptr = (e_sel + 1) % N;
        b = beats_of(int'(in_opcode[e_sel*3 +: 3]), int'(in_size[e_sel*4 +: 4]));
        if (b > 1) begin
          m_lock = e_sel;
          m_left = b - 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) m_lock = -1;
      end
    end
  endfunction

  task automatic apply_reset();
    reset     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    in_valid  = '0;
    for (int c = 0; c < 13; c++) begin
      reset = (c < 3);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 2'b00 || grant_idx !== 3'd0) begin
        errors++;
        $display("FAIL reset_idle c=%0d got v=%b rdy=%b g=%0d exp v=0 rdy=00 g=0",
                 c, out_valid, in_ready, grant_idx);
      end
      @(negedge clock);
    end
    $display("reset: idle outputs observed for 13 cycles");
  endtask

  task automatic test_round_robin();
    int exp;
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive_req(0, 1'b1, 0, 0);
      drive_req(1, 1'b1, 0, 0);
      #1;
      exp = c % 2;
      checks++;
      if (grant_idx !== 3'(exp) || out_valid !== 1'b1 || in_ready !== 2'(1 << exp)) begin
        errors++;
        $display("FAIL rr_grant c=%0d got g=%0d v=%b rdy=%b exp g=%0d v=1", c, grant_idx,
                 out_valid, in_ready, exp);
      end
      checks++;
      if (out_payload() !== payload_of(exp)) begin
        errors++;
        $display("FAIL rr_payload c=%0d got %h exp %h", c, out_payload(), payload_of(exp));
      end
      $display("rr: beat from req%0d", grant_idx);
      @(negedge clock);
    end
  endtask

  task automatic test_burst();
    int exp;
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive_req(0, 1'b1, (c < 4) ? 1 : 0, (c < 4) ? 5 : 0);
      drive_req(1, 1'b1, 0, 0);
      #1;
      exp = (c < 4) ? 0 : (c == 4 ? 1 : 0);
      checks++;
      if (grant_idx !== 3'(exp) || in_ready !== 2'(1 << exp) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL burst_lock c=%0d got g=%0d rdy=%b v=%b exp g=%0d v=1", c, grant_idx,
                 in_ready, out_valid, exp);
      end
      $display("burst: beat from req%0d", grant_idx);
      @(negedge clock);
    end
  endtask

  task automatic test_burst_stall();
    int fires;
    int obs_fires;
    int exp;
    apply_reset();
    fires     = 0;
    obs_fires = 0;
    for (int c = 0; c < 10; c++) begin
      out_ready = (c % 2 == 0);
      drive_req(0, fires < 4, 1, 5);
      drive_req(1, 1'b1, 0, 0);
      #1;
      exp = (fires < 4) ? 0 : 1;
      checks++;
      if (grant_idx !== 3'(exp) || out_valid !== 1'b1 ||
          in_ready !== (out_ready ? 2'(1 << exp) : 2'b00)) begin
        errors++;
        $display("FAIL stall_burst c=%0d got g=%0d v=%b rdy=%b exp g=%0d", c, grant_idx,
                 out_valid, in_ready, exp);
      end
      if (in_valid[0] && in_ready[0]) obs_fires++;
      if (out_ready && exp == 0) fires++;
      @(negedge clock);
    end
    checks++;
    if (obs_fires !== 4) begin
      errors++;
      $display("FAIL stall_burst_count got %0d req0 fires exp 4", obs_fires);
    end
    $display("stall_burst: %0d req0 beats accepted", obs_fires);
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive_req(0, 1'b1, 1, 5);
      drive_req(1, 1'b1, 0, 0);
      #1;
      checks++;
      if (grant_idx !== 3'd0 || in_ready !== 2'b01) begin
        errors++;
        $display("FAIL midrst_pre c=%0d got g=%0d rdy=%b exp g=0 rdy=01", c, grant_idx, in_ready);
      end
      @(negedge clock);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 2'b00) begin
      errors++;
      $display("FAIL midrst_during got v=%b rdy=%b exp v=0 rdy=00", out_valid, in_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    // Both valid, no fire: pointer back at 0 selects req0.
    out_ready = 1'b0;
    drive_req(0, 1'b1, 0, 0);
    drive_req(1, 1'b1, 0, 0);
    #1;
    checks++;
    if (grant_idx !== 3'd0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ptr got g=%0d v=%b exp g=0 v=1", grant_idx, out_valid);
    end
    @(negedge clock);
    // Lock released: req1 alone wins immediately.
    out_ready = 1'b1;
    drive_req(0, 1'b0, 0, 0);
    drive_req(1, 1'b1, 0, 0);
    #1;
    checks++;
    if (grant_idx !== 3'd1 || out_valid !== 1'b1 || in_ready !== 2'b10) begin
      errors++;
      $display("FAIL midrst_unlock got g=%0d v=%b rdy=%b exp g=1 v=1 rdy=10", grant_idx,
               out_valid, in_ready);
    end
    $display("midrst: req%0d granted after reset", grant_idx);
    @(negedge clock);
  endtask

  task automatic test_random();
    int ops[6] = '{0, 1, 5, 4, 2, 1};
    int sz;
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        sz = ($urandom_range(0, 149) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 7);
        drive_req(i, $urandom_range(0, 9) < 6, ops[$urandom_range(0, 5)], sz);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      model_eval();
      checks++;
      if (out_valid !== e_valid || in_ready !== e_ready || grant_idx !== 3'(e_sel)) begin
        errors++;
        $display("FAIL rand_ctrl c=%0d got v=%b rdy=%b g=%0d exp v=%b rdy=%b g=%0d", c,
                 out_valid, in_ready, grant_idx, e_valid, e_ready, e_sel);
      end
      if (e_valid) begin
        checks++;
        if (out_payload() !== payload_of(e_sel)) begin
          errors++;
          $display("FAIL rand_payload c=%0d got %h exp %h", c, out_payload(), payload_of(e_sel));
        end
      end
      model_step();
      @(negedge clock);
    end
    reset = 1'b0;
  endtask

`ifdef DARB_STALL_CNT_EN
  task automatic test_stall_cnt();
    apply_reset();
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stall_cnt_reset got %0d exp 0", stall_cnt);
    end
    out_ready = 1'b0;
    drive_req(0, 1'b1, 0, 0);
    drive_req(1, 1'b0, 0, 0);
    repeat (20) @(negedge clock);
    checks++;
    if (stall_cnt !== 16'd20) begin
      errors++;
      $display("FAIL stall_cnt_20 got %0d exp 20", stall_cnt);
    end
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = '0;
    @(negedge clock);
    checks++;
    if (stall_cnt !== 16'd20) begin
      errors++;
      $display("FAIL stall_cnt_hold got %0d exp 20", stall_cnt);
    end
    $display("stall_cnt: %0d stalled cycles", stall_cnt);
  endtask
`endif

  initial begin
    @(negedge clock);
    test_reset();
    test_round_robin();
    test_burst();
    test_burst_stall();
    test_reset_mid_burst();
    test_random();
`ifdef DARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
